vending_controller_p: RTL and testbench
=======================================

# vending_controller_p

Clocked, parametrised vending-machine controller for an ROWS x COLS selection matrix. It accumulates coin credit, latches a row/column selection, and checks credit against a runtime-programmable price table. On a successful check it dispenses and returns change; the customer can also cancel for a full refund. It sits between the keypad/coin-acceptor front end and the dispense/change-return actuators.

## Interface
- ROWS, 4, number of letter buttons (rows)
- COLS, 4, number of digit buttons (columns)
- WIDTH, 16, width of all money values in cents
- DEFAULT_PRICE, 100, reset value of every price-table entry
- TIMEOUT, 1000, idle cycles after a row press before the latched row is discarded
- SEL_W, derived as $clog2(ROWS*COLS), width of the selection index
- I_CLK  in  1  clock, all logic on the rising edge
- I_RESET  in  1  reset; synchronous, active-high
- I_ROW  in  ROWS  letter buttons, one cycle high per press, at most one bit set
- I_COL  in  COLS  digit buttons, one cycle high per press, at most one bit set
- I_COIN_VALID  in  1  one-cycle strobe, coin inserted
- I_COIN_VALUE  in  WIDTH  coin value; valid with I_COIN_VALID
- I_CANCEL  in  1  one-cycle refund request
- I_PRICE_WE  in  1  price-table write enable
- I_PRICE_ADDR  in  SEL_W  price-table index (row*COLS+col)
- I_PRICE_DATA  in  WIDTH  price to write
- O_CREDIT  out  WIDTH  current accumulated credit
- O_PRICE  out  WIDTH  price of the last checked selection
- O_SEL  out  SEL_W  last dispensed selection index
- O_SUCCESS  out  1  one-cycle pulse, item dispensed
- O_INSUFFICIENT  out  1  one-cycle pulse, credit below price
- O_CHANGE  out  WIDTH  change/refund amount; valid with O_CHANGE_VALID
- O_CHANGE_VALID  out  1  one-cycle pulse, O_CHANGE must be paid out

## Operation
- States: IDLE, ROW_HELD, CHECK.
- Reset: state IDLE, all outputs 0, credit 0, latched row cleared, timeout counter 0, every price entry set to DEFAULT_PRICE.
- Coins are accepted in every state: credit <= credit + I_COIN_VALUE, saturating at 2^WIDTH-1.
- IDLE: a row press latches the row and moves to ROW_HELD. A column press is ignored.
- ROW_HELD:
  - A new row press replaces the latched row (last press wins) and reloads the timeout counter.
  - A column press computes sel = row*COLS + col and moves to CHECK.
  - If no row or column press arrives for TIMEOUT cycles, the row is cleared and the state returns to IDLE. Credit is kept.
- CHECK (one cycle):
  - Register O_PRICE <= price[sel].
  - If credit >= price: O_SEL <= sel, O_SUCCESS = 1, O_CHANGE <= credit - price, O_CHANGE_VALID = 1, credit <= 0. A zero change amount is still reported with O_CHANGE_VALID = 1.
  - Otherwise: O_INSUFFICIENT = 1 and credit is unchanged.
  - Either way the row is cleared and the state returns to IDLE.
- Cancel, in any state:
  - If credit > 0: O_CHANGE <= credit, O_CHANGE_VALID = 1, credit <= 0.
  - Row is cleared and the state returns to IDLE.
  - If credit is 0, no change pulse is issued.
- Price writes are accepted in any state and take effect on the following cycle.

## Timing
- Column press sampled at edge N: state is CHECK in cycle N+1. O_SUCCESS / O_INSUFFICIENT / O_CHANGE_VALID are high in cycle N+2 only. O_PRICE and O_SEL update at N+2 and hold until the next check.
- Coin sampled at edge N: O_CREDIT reflects it from N+1.
- Coin in the same cycle as a successful CHECK: credit becomes the coin value; it is not included in the change.
- Coin in the same cycle as cancel: the coin is included in the refund.
- Cancel together with a row or column press, or during CHECK: cancel wins, with no dispense and no insufficient pulse.
- Price write to index sel during its CHECK cycle: the check uses the old price.
- Reset asserted in any state, including CHECK: reset values on the next edge, and no pulses are emitted.
- O_CHANGE holds its last value between pulses.

## Test plan
- Prices written for A1 = 100, B2 = 250, D4 = 200. Coins 25 x4, row0, col0 -> O_SEL = 0, O_PRICE = 100, O_SUCCESS, O_CHANGE = 0 with O_CHANGE_VALID, O_CREDIT = 0.
- Credit 200, row1, col1 -> O_PRICE = 250, O_INSUFFICIENT, O_CREDIT = 200. Then coin 50, row1, col1 -> O_SUCCESS, O_SEL = 5, O_CHANGE = 0.
- Credit 400, rows 0, 1, 3 pressed in sequence, then col3 -> O_SEL = 15, O_CHANGE = 200, O_SUCCESS.
- Credit 135, I_CANCEL -> O_CHANGE = 135, O_CHANGE_VALID, O_CREDIT = 0. Second cancel -> no pulse.
- TIMEOUT set to 8: row2, idle 8 cycles, then col0 -> no CHECK and no pulses; credit unchanged.
- Credit 65530 (WIDTH = 16) plus coin 500 -> O_CREDIT = 65535. I_RESET asserted during CHECK -> all outputs 0 next cycle and no O_SUCCESS.

Source files
------------

// File: rtl/vending_controller_p.sv
`default_nettype none
// =============================================================================
// Module   : vending_controller_p
// Purpose  : Coin-credit vending controller for a ROWS x COLS selection matrix
//            with a runtime-programmable price table, dispense and refund.
// Revision : 1.0 - initial release
// =============================================================================
module vending_controller_p #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int WIDTH         = 16,
    parameter int DEFAULT_PRICE = 100,
    parameter int TIMEOUT       = 1000,
    parameter int SEL_W         = $clog2(ROWS*COLS)
) (
    input  logic             I_CLK,
    input  logic             I_RESET,
    input  logic [ROWS-1:0]  I_ROW,
    input  logic [COLS-1:0]  I_COL,
    input  logic             I_COIN_VALID,
    input  logic [WIDTH-1:0] I_COIN_VALUE,
    input  logic             I_CANCEL,
    input  logic             I_PRICE_WE,
    input  logic [SEL_W-1:0] I_PRICE_ADDR,
    input  logic [WIDTH-1:0] I_PRICE_DATA,
    output logic [WIDTH-1:0] O_CREDIT,
    output logic [WIDTH-1:0] O_PRICE,
    output logic [SEL_W-1:0] O_SEL,
    output logic             O_SUCCESS,
    output logic             O_INSUFFICIENT,
    output logic [WIDTH-1:0] O_CHANGE,
    output logic             O_CHANGE_VALID
);

    localparam int NSEL  = ROWS * COLS;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [SEL_W:0]   NSEL_L     = (SEL_W+1)'(NSEL);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] PRICE_INIT = WIDTH'(DEFAULT_PRICE);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ROW_HELD = 2'd1,
        S_CHECK    = 2'd2
    } state_t;

    state_t           r_state;
    logic [ROW_W-1:0] r_row;
    logic [TMO_W-1:0] r_tmo;
    logic [SEL_W-1:0] r_check_sel;
    logic [WIDTH-1:0] r_credit;
    logic [WIDTH-1:0] r_price [NSEL];
    logic [WIDTH-1:0] r_price_out;
    logic [SEL_W-1:0] r_sel_out;
    logic             r_success;
    logic             r_insuff;
    logic [WIDTH-1:0] r_change;
    logic             r_change_valid;

    logic [ROW_W-1:0] w_row_idx;
    logic [COL_W-1:0] w_col_idx;
    logic             w_row_press;
    logic             w_col_press;
    logic [SEL_W-1:0] w_sel;
    logic [WIDTH-1:0] w_coin;
    logic [WIDTH:0]   w_sum_ext;
    logic [WIDTH-1:0] w_credit_sum;
    logic [WIDTH-1:0] w_cur_price;
    logic             w_addr_ok;

    function automatic logic [ROW_W-1:0] f_row_idx(input logic [ROWS-1:0] v);
        f_row_idx = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (v[i]) f_row_idx = ROW_W'(i);
        end
    endfunction

    function automatic logic [COL_W-1:0] f_col_idx(input logic [COLS-1:0] v);
        f_col_idx = '0;
        for (int i = 0; i < COLS; i++) begin
            if (v[i]) f_col_idx = COL_W'(i);
        end
    endfunction

    assign w_row_idx   = f_row_idx(I_ROW);
    assign w_col_idx   = f_col_idx(I_COL);
    assign w_row_press = |I_ROW;
    assign w_col_press = |I_COL;
    assign w_sel       = SEL_W'(int'(r_row) * COLS + int'(w_col_idx));

    // Credit plus this cycle's coin, clamped at full scale.
    assign w_coin       = I_COIN_VALID ? I_COIN_VALUE : '0;
    assign w_sum_ext    = {1'b0, r_credit} + {1'b0, w_coin};
    assign w_credit_sum = w_sum_ext[WIDTH] ? {WIDTH{1'b1}} : w_sum_ext[WIDTH-1:0];

    assign w_cur_price = r_price[r_check_sel];
    assign w_addr_ok   = ({1'b0, I_PRICE_ADDR} < NSEL_L);

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_state        <= S_IDLE;
            r_row          <= '0;
            r_tmo          <= '0;
            r_check_sel    <= '0;
            r_credit       <= '0;
            r_price_out    <= '0;
            r_sel_out      <= '0;
            r_success      <= 1'b0;
            r_insuff       <= 1'b0;
            r_change       <= '0;
            r_change_valid <= 1'b0;
            for (int i = 0; i < NSEL; i++) begin
                r_price[i] <= PRICE_INIT;
            end
        end else begin
            r_success      <= 1'b0;
            r_insuff       <= 1'b0;
            r_change_valid <= 1'b0;

            // The check below reads the pre-write price, so a same-cycle write lands afterwards.
            if (I_PRICE_WE && w_addr_ok) begin
                r_price[I_PRICE_ADDR] <= I_PRICE_DATA;
            end

            if (I_CANCEL) begin
                if (w_credit_sum != '0) begin
                    r_change       <= w_credit_sum;
                    r_change_valid <= 1'b1;
                end
                r_credit <= '0;
                r_row    <= '0;
                r_tmo    <= '0;
                r_state  <= S_IDLE;
            end else begin
                r_credit <= w_credit_sum;
                case (r_state)
                    S_IDLE: begin
                        if (w_row_press) begin
                            r_row   <= w_row_idx;
                            r_tmo   <= '0;
                            r_state <= S_ROW_HELD;
                        end
                    end
                    S_ROW_HELD: begin
                        if (w_row_press) begin
                            r_row <= w_row_idx;
                            r_tmo <= '0;
                        end else if (w_col_press) begin
                            r_check_sel <= w_sel;
                            r_tmo       <= '0;
                            r_state     <= S_CHECK;
                        end else if (r_tmo == TMO_LAST) begin
                            r_row   <= '0;
                            r_tmo   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                    S_CHECK: begin
                        r_price_out <= w_cur_price;
                        if (r_credit >= w_cur_price) begin
                            r_sel_out      <= r_check_sel;
                            r_success      <= 1'b1;
                            r_change       <= r_credit - w_cur_price;
                            r_change_valid <= 1'b1;
                            // A coin landing now starts the next purchase's credit.
                            r_credit       <= w_coin;
                        end else begin
                            r_insuff <= 1'b1;
                        end
                        r_row   <= '0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_row   <= '0;
                        r_tmo   <= '0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign O_CREDIT       = r_credit;
    assign O_PRICE        = r_price_out;
    assign O_SEL          = r_sel_out;
    assign O_SUCCESS      = r_success;
    assign O_INSUFFICIENT = r_insuff;
    assign O_CHANGE       = r_change;
    assign O_CHANGE_VALID = r_change_valid;

endmodule
`default_nettype wire

// File: tb/tb_vending_controller_p.sv
`default_nettype none
// =============================================================================
// Module   : tb_vending_controller_p
// Purpose  : Directed and randomized bench for vending_controller_p against a
//            cycle-level purchase model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_vending_controller_p;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int WIDTH = 16;
    localparam int NSEL = ROWS * COLS;
    localparam int TMO = 8;
    localparam int MAXC = 65535;

    logic              clk;
    logic              I_RESET;
    logic [ROWS-1:0]   I_ROW;
    logic [COLS-1:0]   I_COL;
    logic              I_COIN_VALID;
    logic [WIDTH-1:0]  I_COIN_VALUE;
    logic              I_CANCEL;
    logic              I_PRICE_WE;
    logic [3:0]        I_PRICE_ADDR;
    logic [WIDTH-1:0]  I_PRICE_DATA;
    logic [WIDTH-1:0]  O_CREDIT;
    logic [WIDTH-1:0]  O_PRICE;
    logic [3:0]        O_SEL;
    logic              O_SUCCESS;
    logic              O_INSUFFICIENT;
    logic [WIDTH-1:0]  O_CHANGE;
    logic              O_CHANGE_VALID;

    vending_controller_p #(
        .ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH),
        .DEFAULT_PRICE(100), .TIMEOUT(TMO)
    ) dut (
        .I_CLK(clk), .I_RESET(I_RESET), .I_ROW(I_ROW), .I_COL(I_COL),
        .I_COIN_VALID(I_COIN_VALID), .I_COIN_VALUE(I_COIN_VALUE),
        .I_CANCEL(I_CANCEL), .I_PRICE_WE(I_PRICE_WE),
        .I_PRICE_ADDR(I_PRICE_ADDR), .I_PRICE_DATA(I_PRICE_DATA),
        .O_CREDIT(O_CREDIT), .O_PRICE(O_PRICE), .O_SEL(O_SEL),
        .O_SUCCESS(O_SUCCESS), .O_INSUFFICIENT(O_INSUFFICIENT),
        .O_CHANGE(O_CHANGE), .O_CHANGE_VALID(O_CHANGE_VALID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Purchase model: credit, price list, held row with idle count, pending check.
    int m_credit;
    int m_price [NSEL];
    bit m_held;
    int m_row;
    int m_idle;
    bit m_pend;
    int m_psel;
    int e_price, e_sel, e_change;
    bit e_succ, e_ins, e_cv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_credit = 0;
        for (int i = 0; i < NSEL; i++) m_price[i] = 100;
        m_held = 0; m_row = 0; m_idle = 0; m_pend = 0; m_psel = 0;
        e_price = 0; e_sel = 0; e_change = 0;
        e_succ = 0; e_ins = 0; e_cv = 0;
    endtask

    task automatic step(input int row, input int col, input int coin, input bit cancel,
                        input bit we, input int addr, input int data, input bit rst);
        int sum;
        int c;
        @(negedge clk);
        I_RESET      = rst;
        I_ROW        = (row >= 0) ? ROWS'(1 << row) : '0;
        I_COL        = (col >= 0) ? COLS'(1 << col) : '0;
        I_COIN_VALID = (coin >= 0);
        I_COIN_VALUE = (coin >= 0) ? WIDTH'(coin) : '0;
        I_CANCEL     = cancel;
        I_PRICE_WE   = we;
        I_PRICE_ADDR = 4'(addr);
        I_PRICE_DATA = WIDTH'(data);
        @(posedge clk);
        e_succ = 0; e_ins = 0; e_cv = 0;
        if (rst) begin
            model_reset();
        end else begin
            c = (coin >= 0) ? coin : 0;
            sum = m_credit + c;
            if (sum > MAXC) sum = MAXC;
            if (cancel) begin
                if (sum > 0) begin
                    e_change = sum; e_cv = 1;
                end
                m_credit = 0; m_held = 0; m_pend = 0;
            end else if (m_pend) begin
                e_price = m_price[m_psel];
                if (m_credit >= m_price[m_psel]) begin
                    e_sel = m_psel; e_succ = 1; e_cv = 1;
                    e_change = m_credit - m_price[m_psel];
                    m_credit = c;
                end else begin
                    e_ins = 1;
                    m_credit = sum;
                end
                m_pend = 0; m_held = 0;
            end else begin
                m_credit = sum;
                if (row >= 0) begin
                    m_held = 1; m_row = row; m_idle = 0;
                end else if (m_held && col >= 0) begin
                    m_pend = 1; m_psel = m_row * COLS + col; m_held = 0;
                end else if (m_held) begin
                    m_idle++;
                    if (m_idle == TMO) m_held = 0;
                end
            end
            if (we) m_price[addr] = data;
        end
        #1;
        chk("credit", 32'(O_CREDIT), 32'(m_credit));
        chk("success", 32'(O_SUCCESS), 32'(e_succ));
        chk("insufficient", 32'(O_INSUFFICIENT), 32'(e_ins));
        chk("change_valid", 32'(O_CHANGE_VALID), 32'(e_cv));
        chk("change", 32'(O_CHANGE), 32'(e_change));
        chk("price", 32'(O_PRICE), 32'(e_price));
        chk("sel", 32'(O_SEL), 32'(e_sel));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(-1, -1, -1, 0, 0, 0, 0, 0);
    endtask
    task automatic coin(input int v);
        step(-1, -1, v, 0, 0, 0, 0, 0);
    endtask
    task automatic prow(input int r);
        step(r, -1, -1, 0, 0, 0, 0, 0);
    endtask
    task automatic pcol(input int c);
        step(-1, c, -1, 0, 0, 0, 0, 0);
    endtask
    task automatic wprice(input int a, input int d);
        step(-1, -1, -1, 0, 1, a, d, 0);
    endtask

    initial begin
        int r, c, cv, k;
        bit ca, we, rs;
        model_reset();
        step(-1, -1, -1, 0, 0, 0, 0, 1);
        step(-1, -1, -1, 0, 0, 0, 0, 1);
        chk("reset_credit", 32'(O_CREDIT), 32'd0);
        chk("reset_change", 32'(O_CHANGE), 32'd0);

        // A1=100, B2=250, D4=200; exact-credit purchase gives zero change.
        wprice(0, 100); wprice(5, 250); wprice(15, 200);
        for (int i = 0; i < 4; i++) coin(25);
        prow(0); pcol(0); idle(1);
        chk("a1_success", 32'(O_SUCCESS), 32'd1);
        chk("a1_sel", 32'(O_SEL), 32'd0);
        chk("a1_price", 32'(O_PRICE), 32'd100);
        chk("a1_change", 32'(O_CHANGE), 32'd0);
        chk("a1_cv", 32'(O_CHANGE_VALID), 32'd1);
        idle(1);

        coin(100); coin(100); prow(1); pcol(1); idle(1);
        chk("b2_insuff", 32'(O_INSUFFICIENT), 32'd1);
        chk("b2_price", 32'(O_PRICE), 32'd250);
        chk("b2_credit", 32'(O_CREDIT), 32'd200);
        coin(50); prow(1); pcol(1); idle(1);
        chk("b2_success", 32'(O_SUCCESS), 32'd1);
        chk("b2_sel", 32'(O_SEL), 32'd5);

        for (int i = 0; i < 4; i++) coin(100);
        prow(0); prow(1); prow(3); pcol(3); idle(1);
        chk("d4_sel", 32'(O_SEL), 32'd15);
        chk("d4_change", 32'(O_CHANGE), 32'd200);

        coin(100); coin(25); coin(10);
        step(-1, -1, -1, 1, 0, 0, 0, 0);
        chk("cancel_change", 32'(O_CHANGE), 32'd135);
        chk("cancel_cv", 32'(O_CHANGE_VALID), 32'd1);
        step(-1, -1, -1, 1, 0, 0, 0, 0);
        chk("cancel2_cv", 32'(O_CHANGE_VALID), 32'd0);

        // Timeout: row dropped after TMO idle cycles, later column ignored.
        coin(500); prow(2); idle(TMO); pcol(0); idle(2);
        chk("tmo_credit", 32'(O_CREDIT), 32'd500);
        chk("tmo_nosucc", 32'(O_SUCCESS), 32'd0);

        // Coin during a successful check; coin with cancel; cancel beats column.
        coin(300); prow(2); pcol(2); coin(40); idle(1);
        chk("coin_in_check", 32'(O_CREDIT), 32'd40);
        step(-1, -1, 60, 1, 0, 0, 0, 0);
        chk("coin_cancel", 32'(O_CHANGE), 32'd100);
        coin(300); prow(2); step(-1, 2, -1, 1, 0, 0, 0, 0); idle(2);
        // Price write during CHECK still uses the old price.
        coin(100); prow(3); pcol(2); step(-1, -1, -1, 0, 1, 14, 500, 0); idle(1);

        // Saturation, then reset during CHECK.
        step(-1, -1, -1, 0, 0, 0, 0, 1);
        coin(65530); coin(500);
        chk("sat_credit", 32'(O_CREDIT), 32'd65535);
        prow(0); pcol(0);
        step(-1, -1, -1, 0, 0, 0, 0, 1);
        chk("rst_check_succ", 32'(O_SUCCESS), 32'd0);
        chk("rst_check_credit", 32'(O_CREDIT), 32'd0);
        idle(2);

        for (int n = 0; n < 3000; n++) begin
            r = -1; c = -1; cv = -1;
            k = (n < 1500) ? $urandom_range(0, 99) : $urandom_range(0, 299);
            if (k < 18) r = $urandom_range(0, 3);
            else if (k < 40) c = $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 6))
                    0: cv = 5;
                    1: cv = 10;
                    2: cv = 25;
                    3: cv = 50;
                    4: cv = 100;
                    5: cv = 1000;
                    default: cv = 30000;
                endcase
            end
            ca = ($urandom_range(0, 39) == 0);
            we = ($urandom_range(0, 15) == 0);
            rs = ($urandom_range(0, 299) == 0);
            step(r, c, cv, ca, we, $urandom_range(0, 15), $urandom_range(0, 400), rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
